// File: rtl/fft_stream_io.sv
// Valid/ready front/back-end for the radix-4 FFT core: scatters one frame of samples over
// the four RAM_A banks, starts the core, then reads the banks back as an output stream.
module fft_stream_io #(
    parameter int DATA_W      = 16,
    parameter int BANK_ADDR_W = 9,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic [DATA_W-1:0]         iIN_DATA,
    input  logic                      iIN_VALID,
    output logic                      oIN_READY,
    output logic [DATA_W-1:0]         oWR_DATA,
    output logic [BANK_ADDR_W-1:0]    oADDR_WR,
    output logic [3:0]                oWE,
    output logic                      oCORE_START,
    input  logic                      iCORE_RDY,
    output logic [BANK_ADDR_W-1:0]    oADDR_RD,
    input  logic [4*(DATA_W+1)-1:0]   iRD_DATA,
    output logic [DATA_W:0]           oOUT_DATA,
    output logic                      oOUT_VALID,
    input  logic                      iOUT_READY,
    output logic                      oOUT_LAST,
    output logic                      oBUSY,
    output logic                      oERR
);

    localparam int IDX_W = BANK_ADDR_W + 2;
    localparam int RUN_W = ($clog2(TIMEOUT + 1) < 2) ? 2 : $clog2(TIMEOUT + 1);
    localparam int LAT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_EMIT
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           k_q, k_d;
    logic [3:0]                 we_q, we_d;
    logic [BANK_ADDR_W-1:0]     addr_wr_q, addr_wr_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;
    logic                       start_q, start_d;
    logic [RUN_W-1:0]           run_cnt_q, run_cnt_d;
    logic                       err_q, err_d;
    logic [BANK_ADDR_W-1:0]     a_q, a_d;
    logic [LAT_W-1:0]           lat_cnt_q, lat_cnt_d;
    logic [3:0][DATA_W:0]       hold_q, hold_d;
    logic [1:0]                 j_q, j_d;

    logic                       in_ready;
    logic                       in_fire;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign in_fire  = iIN_VALID && in_ready;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        we_d      = 4'b0000;
        addr_wr_d = addr_wr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        run_cnt_d = run_cnt_q;
        err_d     = err_q;
        a_d       = a_q;
        lat_cnt_d = lat_cnt_q;
        hold_d    = hold_q;
        j_d       = j_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_fire) begin
                    we_d      = 4'b0001 << k_q[1:0];
                    addr_wr_d = k_q[IDX_W-1:2];
                    wr_data_d = iIN_DATA;
                    k_d       = k_q + IDX_W'(1);
                    err_d     = 1'b0;
                    state_d   = S_LOAD;
                    if (k_q == '1) begin
                        state_d   = S_RUN;
                        start_d   = 1'b1;
                        run_cnt_d = '0;
                    end
                end
            end

            S_RUN: begin
                // The core's ready level is stale for the first two cycles after the start pulse.
                if (iCORE_RDY && (run_cnt_q >= RUN_W'(2))) begin
                    state_d = S_RD_ISSUE;
                    a_d     = '0;
                end else if (run_cnt_q == RUN_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end

            S_RD_ISSUE: begin
                lat_cnt_d = '0;
                state_d   = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
                    hold_d  = iRD_DATA;
                    j_d     = 2'd0;
                    state_d = S_EMIT;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end

            S_EMIT: begin
                if (iOUT_READY) begin
                    j_d = j_q + 2'd1;
                    if (j_q == 2'd3) begin
                        if (a_q == '1) begin
                            state_d = S_IDLE;
                        end else begin
                            a_d     = a_q + BANK_ADDR_W'(1);
                            state_d = S_RD_ISSUE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            // NOTE: the holding register is only four words and drives oOUT_DATA, so it is reset too.
            state_q   <= S_IDLE;
            k_q       <= '0;
            we_q      <= 4'b0000;
            addr_wr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
            a_q       <= '0;
            lat_cnt_q <= '0;
            hold_q    <= '0;
            j_q       <= 2'd0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            k_q       <= k_d;
            we_q      <= we_d;
            addr_wr_q <= addr_wr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
            a_q       <= a_d;
            lat_cnt_q <= lat_cnt_d;
            hold_q    <= hold_d;
            j_q       <= j_d;
        end
    end

    assign oIN_READY   = in_ready;
    assign oWR_DATA    = wr_data_q;
    assign oADDR_WR    = addr_wr_q;
    assign oWE         = we_q;
    assign oCORE_START = start_q;
    // The read address only moves on entry to RD_ISSUE, so it holds between bursts.
    assign oADDR_RD    = a_q;
    assign oOUT_DATA   = hold_q[j_q];
    assign oOUT_VALID  = (state_q == S_EMIT);
    assign oOUT_LAST   = (state_q == S_EMIT) && (a_q == '1) && (j_q == 2'd3);
    assign oBUSY       = (state_q != S_IDLE);
    assign oERR        = err_q;

endmodule
